flash_boot_loader: RTL and testbench
====================================

FLASH_BOOT_LOADER -- requirements
Module: flash_boot_loader

Interface
REQ-001 The block SHALL have parameter ROM_SIZE, default 8: number of 16-bit words to load, range 1..65536.
REQ-002 The block SHALL have parameter FLASH_ADDR, default 24'h000000: flash byte address of word 0.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RST_N, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port RELOAD, input, 1 bit: a one-cycle pulse that requests a re-boot.
REQ-006 The block SHALL have port FLASH_SSB, output, 1 bit: SPI chip select, active-low.
REQ-007 The block SHALL have port FLASH_SCK, output, 1 bit: SPI clock, SPI mode 0.
REQ-008 The block SHALL have port FLASH_IO0, output, 1 bit: MOSI.
REQ-009 The block SHALL have port FLASH_IO1, input, 1 bit: MISO.
REQ-010 The block SHALL have port ROM_WE, output, 1 bit: ROM write strobe, one CLK per word.
REQ-011 The block SHALL have port ROM_ADDR, output, clog2(ROM_SIZE) bits (minimum 1): ROM word index.
REQ-012 The block SHALL have port ROM_DATA, output, 16 bits: ROM write data.
REQ-013 The block SHALL have port CPU_RESET, output, 1 bit: high while the ROM contents are invalid.
REQ-014 The block SHALL have port DONE, output, 1 bit: high once the load is complete.

Function
REQ-015 The state machine SHALL have the states IDLE, SETUP, CMD, DATA, HOLD and DONE, all registered; every output SHALL be a register.
REQ-016 IDLE SHALL be entered on reset and SHALL go to SETUP on the first cycle after RST_N goes high.
REQ-017 SETUP SHALL last 1 cycle with FLASH_SSB=0, FLASH_SCK=0 and FLASH_IO0 = MSB of the command stream, then go to CMD.
REQ-018 The command stream SHALL be 32 bits, MSB first: 8'h03 followed by FLASH_ADDR[23:0].
REQ-019 Each SPI bit SHALL take 2 CLK cycles: an SCK-low cycle, then an SCK-high cycle.
REQ-020 FLASH_IO0 SHALL change only on the SCK 1->0 transition, or at SETUP entry.
REQ-021 CMD SHALL shift out 32 bits; after the 32nd SCK-high cycle the state SHALL go to DATA, and FLASH_IO0 SHALL be held at 0 in DATA.
REQ-022 In DATA, FLASH_IO1 SHALL be sampled in the same CLK edge that drives FLASH_SCK 0->1, using the pre-edge value.
REQ-023 Sampled bits SHALL be shifted MSB first into a 16-bit shift register.
REQ-024 After every 16th data bit, on the next cycle: ROM_WE=1 for exactly 1 cycle, ROM_DATA = the assembled word, ROM_ADDR = word index (0..ROM_SIZE-1, incrementing by 1).
REQ-025 ROM_WE pulses SHALL overlap continued SCK toggling; SCK SHALL NOT pause between words.
REQ-026 After the ROM_SIZE-th word the state SHALL go to HOLD: FLASH_SCK=0 for 1 cycle, then FLASH_SSB=1, then DONE.
REQ-027 In DONE: DONE=1, CPU_RESET=0, FLASH_SSB=1, FLASH_SCK=0, ROM_WE=0.
REQ-028 The total time from RST_N rising to DONE=1 SHALL be exactly 2*(32+16*ROM_SIZE)+4 CLK cycles.
REQ-029 A RELOAD pulse in DONE SHALL, on the next cycle, set DONE=0, set CPU_RESET=1 and enter SETUP, repeating the sequence with ROM_ADDR restarting at 0.
REQ-030 RELOAD in any state other than DONE SHALL be ignored.
REQ-031 If ROM_WE of the last word coincides with entry to HOLD, the write SHALL still occur.
REQ-032 The word counter SHALL compare against ROM_SIZE-1 without wrap; ROM_SIZE=1 SHALL produce exactly one write.
REQ-033 CPU_RESET SHALL equal NOT DONE at all times.

Reset
REQ-034 While RST_N=0 at a CLK edge, the outputs SHALL be: FLASH_SSB=1, FLASH_SCK=0, FLASH_IO0=0, ROM_WE=0, ROM_ADDR=0, ROM_DATA=0, DONE=0, CPU_RESET=1, and the state SHALL be IDLE.
REQ-035 Reset asserted mid-transfer (in any state) SHALL abort the transfer: FLASH_SSB=1 and no further ROM_WE on the next edge; the full sequence SHALL restart from SETUP after release.
REQ-036 No partial word SHALL be written on abort.

Verification
REQ-037 Boot with ROM_SIZE=8 against the bit-serial flash model preloaded with words 16'h0001..16'h0008 -> exactly 8 ROM_WE pulses; ROM_ADDR 0..7 carries data 0001..0008; DONE rises exactly 324 cycles after RST_N release.
REQ-038 Command capture with FLASH_ADDR=24'h100000 -> MOSI bits sampled on the first 32 SCK rising edges equal 32'h03100000; SSB low throughout the transfer.
REQ-039 Boundary word 16'h8001 at index 7 with ROM_SIZE=8 -> ROM_DATA=8001 written at ROM_ADDR=7; no write at ROM_ADDR=0 after it (no wrap).
REQ-040 RST_N low for 1 cycle during the 3rd word -> SSB=1 on the next edge; no write for word 2; after release, 8 full writes; DONE at 324 cycles after the release.
REQ-041 RELOAD pulse in DONE, then a second RELOAD 10 cycles later -> exactly one re-boot; CPU_RESET high for exactly 324 cycles; identical ROM write sequence.
REQ-042 ROM_SIZE=1 -> exactly one ROM_WE pulse, at ROM_ADDR=0; DONE after 100 cycles.

Source files
------------

// File: rtl/flash_boot_loader.sv
// rtl/flash_boot_loader.sv - SPI flash to on-chip ROM boot loader
// Issues a 0x03 read at FLASH_ADDR and writes ROM_SIZE big-endian 16-bit words into the ROM.
module flash_boot_loader #(
  parameter int          ROM_SIZE   = 8,
  parameter logic [23:0] FLASH_ADDR = 24'h000000,
  localparam int         AW         = (ROM_SIZE > 1) ? $clog2(ROM_SIZE) : 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          RELOAD,
  output logic          FLASH_SSB,
  output logic          FLASH_SCK,
  output logic          FLASH_IO0,
  input  logic          FLASH_IO1,
  output logic          ROM_WE,
  output logic [AW-1:0] ROM_ADDR,
  output logic [15:0]   ROM_DATA,
  output logic          CPU_RESET,
  output logic          DONE
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_CMD, S_DATA, S_HOLD, S_DONE} state_t;

  localparam logic [31:0]   CMD_WORD = {8'h03, FLASH_ADDR};
  localparam logic [AW-1:0] LAST     = AW'(ROM_SIZE - 1);

  state_t        r_state;
  logic [31:0]   r_cmd;
  logic [4:0]    r_cnt;
  logic [3:0]    r_dbit;
  logic [AW-1:0] r_wcnt;
  logic [15:0]   r_shift;
  logic          r_pend;
  logic [1:0]    r_hcnt;
  logic          w_start;

  assign w_start = (r_state == S_IDLE) || ((r_state == S_DONE) && RELOAD);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      FLASH_SSB <= 1'b1;
      FLASH_SCK <= 1'b0;
      FLASH_IO0 <= 1'b0;
      ROM_WE    <= 1'b0;
      ROM_ADDR  <= '0;
      ROM_DATA  <= '0;
      DONE      <= 1'b0;
      CPU_RESET <= 1'b1;
      r_cmd     <= '0;
      r_cnt     <= '0;
      r_dbit    <= '0;
      r_wcnt    <= '0;
      r_shift   <= '0;
      r_pend    <= 1'b0;
      r_hcnt    <= '0;
    end else begin
      ROM_WE <= 1'b0;
      if (w_start) begin
        r_state   <= S_SETUP;
        FLASH_SSB <= 1'b0;
        FLASH_SCK <= 1'b0;
        FLASH_IO0 <= CMD_WORD[31];
        r_cmd     <= {CMD_WORD[30:0], 1'b0};
        r_cnt     <= '0;
        r_dbit    <= '0;
        r_wcnt    <= '0;
        r_pend    <= 1'b0;
        r_hcnt    <= '0;
        DONE      <= 1'b0;
        CPU_RESET <= 1'b1;
      end else begin
        case (r_state)
          S_SETUP: r_state <= S_CMD;
          S_CMD: begin
            FLASH_SCK <= ~FLASH_SCK;
            if (FLASH_SCK) begin
              if (r_cnt == 5'd31) begin
                r_state   <= S_DATA;
                FLASH_IO0 <= 1'b0;
              end else begin
                FLASH_IO0 <= r_cmd[31];
                r_cmd     <= {r_cmd[30:0], 1'b0};
                r_cnt     <= r_cnt + 5'd1;
              end
            end
          end
          S_DATA: begin
            FLASH_SCK <= ~FLASH_SCK;
            if (!FLASH_SCK) begin
              // MISO was set up on the previous falling SCK, so the pre-edge value is the data bit
              r_shift <= {r_shift[14:0], FLASH_IO1};
              r_dbit  <= r_dbit + 4'd1;
              if (r_dbit == 4'd15) r_pend <= 1'b1;
            end else if (r_pend) begin
              r_pend   <= 1'b0;
              ROM_WE   <= 1'b1;
              ROM_DATA <= r_shift;
              ROM_ADDR <= r_wcnt;
              if (r_wcnt == LAST) r_state <= S_HOLD;
              else r_wcnt <= r_wcnt + AW'(1);
            end
          end
          S_HOLD: begin
            // one SCK-low cycle with SSB still low, then two cycles of deselect before DONE
            r_hcnt <= r_hcnt + 2'd1;
            if (r_hcnt == 2'd0) FLASH_SSB <= 1'b1;
            if (r_hcnt == 2'd2) begin
              r_state   <= S_DONE;
              DONE      <= 1'b1;
              CPU_RESET <= 1'b0;
            end
          end
          S_DONE: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flash_boot_loader.sv
// tb/tb_flash_boot_loader.sv - directed scoreboard bench for flash_boot_loader
// Two instances: ROM_SIZE=8 at flash 0x100000 and ROM_SIZE=1 at flash 0x000000.
module tb_flash_boot_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n0 = 1'b0, rst_n1 = 1'b0, reload0 = 1'b0, reload1 = 1'b0;
  logic ssb0, sck0, mosi0, we0, done0, cpu0;
  logic ssb1, sck1, mosi1, we1, done1, cpu1;
  logic miso0 = 1'b0, miso1 = 1'b0;
  logic [2:0]  addr0;
  logic [0:0]  addr1;
  logic [15:0] data0, data1;

  int n_cmp = 0, n_err = 0;
  logic [15:0] mem0 [8];
  logic [15:0] mem1;
  logic [31:0] sb0 [$];
  logic [31:0] sb1 [$];
  int wcnt0 = 0, wcnt1 = 0, cnt0 = 0, cnt1 = 0;
  logic [31:0] cap0 = '0, cap1 = '0, exp0, exp1;
  int cyc, hi;

  flash_boot_loader #(.ROM_SIZE(8), .FLASH_ADDR(24'h100000)) dut8 (
    .CLK(clk), .RST_N(rst_n0), .RELOAD(reload0), .FLASH_SSB(ssb0), .FLASH_SCK(sck0),
    .FLASH_IO0(mosi0), .FLASH_IO1(miso0), .ROM_WE(we0), .ROM_ADDR(addr0), .ROM_DATA(data0),
    .CPU_RESET(cpu0), .DONE(done0));

  flash_boot_loader #(.ROM_SIZE(1), .FLASH_ADDR(24'h000000)) dut1 (
    .CLK(clk), .RST_N(rst_n1), .RELOAD(reload1), .FLASH_SSB(ssb1), .FLASH_SCK(sck1),
    .FLASH_IO0(mosi1), .FLASH_IO1(miso1), .ROM_WE(we1), .ROM_ADDR(addr1), .ROM_DATA(data1),
    .CPU_RESET(cpu1), .DONE(done1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic flash_bit0(input int d);
    if (d / 16 < 8) return mem0[d / 16][15 - (d % 16)];
    return 1'b0;
  endfunction

  function automatic logic flash_bit1(input int d);
    if (d < 16) return mem1[15 - d];
    return 1'b0;
  endfunction

  // bit-serial flash models, SPI mode 0: capture on rising SCK, drive on falling SCK
  always @(posedge ssb0) begin cnt0 = 0; miso0 = 1'b0; end
  always @(negedge ssb0) cnt0 = 0;
  always @(posedge sck0) begin
    check("ssb_low_on_sck0", 32'(ssb0), 32'd0);
    if (cnt0 < 32) cap0 = {cap0[30:0], mosi0};
    else check("mosi_idle_in_data0", 32'(mosi0), 32'd0);
    cnt0++;
  end
  always @(negedge sck0) if (cnt0 >= 32) miso0 = flash_bit0(cnt0 - 32);

  always @(posedge ssb1) begin cnt1 = 0; miso1 = 1'b0; end
  always @(negedge ssb1) cnt1 = 0;
  always @(posedge sck1) begin
    check("ssb_low_on_sck1", 32'(ssb1), 32'd0);
    if (cnt1 < 32) cap1 = {cap1[30:0], mosi1};
    cnt1++;
  end
  always @(negedge sck1) if (cnt1 >= 32) miso1 = flash_bit1(cnt1 - 32);

  // ROM write monitor: every strobe consumes one scoreboard entry
  always @(negedge clk) begin
    if (we0 === 1'b1) begin
      wcnt0++;
      if (sb0.size() == 0) check("unexpected_write0", {13'd0, addr0, data0}, 32'hFFFF_FFFF);
      else begin
        exp0 = sb0.pop_front();
        check("rom_write0", {13'd0, addr0, data0}, exp0);
      end
    end
    if (we1 === 1'b1) begin
      wcnt1++;
      if (sb1.size() == 0) check("unexpected_write1", {15'd0, addr1, data1}, 32'hFFFF_FFFF);
      else begin
        exp1 = sb1.pop_front();
        check("rom_write1", {15'd0, addr1, data1}, exp1);
      end
    end
  end

  task automatic push8();
    wcnt0 = 0;
    for (int i = 0; i < 8; i++) sb0.push_back({16'(i), mem0[i]});
  endtask

  task automatic wait_done(input int idx, output int c, output int h);
    c = 0;
    h = 0;
    while (((idx == 0) ? done0 : done1) !== 1'b1 && c < 2000) begin
      if (((idx == 0) ? cpu0 : cpu1) === 1'b1) h++;
      @(posedge clk); #1;
      c++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) mem0[i] = 16'(i + 1);
    mem1 = 16'hA5C3;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl0", 32'({ssb0, sck0, mosi0, we0, done0, cpu0}), 32'h21);
    check("reset_rom0", {13'd0, addr0, data0}, 32'd0);
    check("reset_ctl1", 32'({ssb1, sck1, mosi1, we1, done1, cpu1}), 32'h21);
    check("reset_rom1", {15'd0, addr1, data1}, 32'd0);

    // first boot from reset release
    push8();
    @(negedge clk); rst_n0 = 1'b1;
    @(posedge clk); #1;
    check("setup_pins", 32'({ssb0, sck0, mosi0}), 32'd0);
    wait_done(0, cyc, hi);
    check("boot_cycles", 32'(cyc), 32'd324);
    check("boot_writes", 32'(wcnt0), 32'd8);
    check("boot_sb_left", 32'(sb0.size()), 32'd0);
    check("cmd_capture", cap0, 32'h0310_0000);
    check("done_pins", 32'({ssb0, sck0, we0, done0, cpu0}), 32'h12);

    // reboot, then abort with a one-cycle reset during the third word
    push8();
    @(negedge clk); reload0 = 1'b1;
    @(posedge clk); #1; reload0 = 1'b0;
    cyc = 0;
    while (wcnt0 < 2 && cyc < 1000) begin @(posedge clk); #1; cyc++; end
    check("abort_reach_word2", 32'(wcnt0), 32'd2);
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n0 = 1'b0;
    @(posedge clk); #1;
    check("abort_pins", 32'({ssb0, we0, done0, cpu0}), 32'h9);
    @(negedge clk);
    check("abort_no_word2", 32'(wcnt0), 32'd2);
    sb0.delete();
    push8();
    rst_n0 = 1'b1;
    @(posedge clk); #1;
    wait_done(0, cyc, hi);
    check("abort_boot_cycles", 32'(cyc), 32'd324);
    check("abort_boot_writes", 32'(wcnt0), 32'd8);
    check("abort_sb_left", 32'(sb0.size()), 32'd0);

    // reload in DONE, with a second reload mid-boot that must be ignored
    push8();
    @(negedge clk); reload0 = 1'b1;
    @(posedge clk); #1; reload0 = 1'b0;
    check("reload_pins", 32'({done0, cpu0, ssb0}), 32'h2);
    fork
      wait_done(0, cyc, hi);
      begin
        repeat (10) @(negedge clk);
        reload0 = 1'b1;
        @(negedge clk);
        reload0 = 1'b0;
      end
    join
    check("reload_cycles", 32'(cyc), 32'd324);
    check("reload_cpu_reset_high", 32'(hi), 32'd324);
    check("reload_writes", 32'(wcnt0), 32'd8);
    check("reload_sb_left", 32'(sb0.size()), 32'd0);

    // MSB-set boundary word at the last index, and no wrap afterwards
    mem0[7] = 16'h8001;
    push8();
    @(negedge clk); reload0 = 1'b1;
    @(posedge clk); #1; reload0 = 1'b0;
    wait_done(0, cyc, hi);
    check("boundary_cycles", 32'(cyc), 32'd324);
    repeat (20) @(posedge clk);
    #1;
    check("boundary_writes", 32'(wcnt0), 32'd8);
    check("boundary_sb_left", 32'(sb0.size()), 32'd0);
    check("boundary_last_data", {13'd0, addr0, data0}, 32'h0007_8001);
    check("done_stays", 32'({done0, cpu0}), 32'h2);

    // single-word ROM
    sb1.push_back({16'd0, mem1});
    @(negedge clk); rst_n1 = 1'b1;
    @(posedge clk); #1;
    wait_done(1, cyc, hi);
    check("size1_cycles", 32'(cyc), 32'd100);
    repeat (5) @(posedge clk);
    #1;
    check("size1_writes", 32'(wcnt1), 32'd1);
    check("size1_sb_left", 32'(sb1.size()), 32'd0);
    check("size1_cmd", cap1, 32'h0300_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
